// File: rtl/hash_msg_feeder.sv
// Message initiator for hash_top: buffers {eom, byte} entries, replays them
// through the load_byte handshake and returns the digest over valid/ready.
module hash_msg_feeder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_eom,
    output logic        in_ready,
    output logic        start_msg,
    output logic [7:0]  msg_byte,
    output logic        valid_in,
    output logic        msg_done,
    input  logic        load_byte,
    input  logic        round_exec_active,
    input  logic [7:0]  digest [7:0],
    input  logic        digest_ready,
    output logic [63:0] out_digest,
    output logic [15:0] out_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic [2:0] {
        IDLE, WAIT_RND, DRIVE, HOLD, WAIT_DIG, OUT
    } state_t;

    state_t state;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          push;
    logic          pop;
    logic          empty;
    logic          head_eom;
    logic [7:0]    head_byte;
    logic [15:0]   len_cnt;
    logic          dr_q;
    logic          dig_rise;

    assign empty     = (count == '0);
    assign head_eom  = mem[rd_ptr][8];
    assign head_byte = mem[rd_ptr][7:0];
    assign push      = in_valid && in_ready;
    assign dig_rise  = digest_ready && !dr_q;

    // Data bytes leave the FIFO only after the core has latched them.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:     pop = !empty && head_eom;
            WAIT_RND: pop = !empty && !round_exec_active && head_eom;
            HOLD:     pop = 1'b1;
            default:  pop = 1'b0;
        endcase
    end

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + ONE;
        end else if (pop && !push) begin
            count_n = count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_eom, in_byte};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_n;
            in_ready <= (count_n != FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            start_msg  <= 1'b0;
            msg_byte   <= '0;
            valid_in   <= 1'b0;
            msg_done   <= 1'b0;
            out_digest <= '0;
            out_len    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            len_cnt    <= '0;
            dr_q       <= 1'b0;
        end else begin
            start_msg <= 1'b0;
            msg_done  <= 1'b0;
            dr_q      <= digest_ready;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        start_msg <= 1'b1;
                        len_cnt   <= '0;
                        busy      <= 1'b1;
                        if (head_eom) begin
                            msg_done <= 1'b1;
                            state    <= WAIT_DIG;
                        end else begin
                            state <= WAIT_RND;
                        end
                    end
                end
                WAIT_RND: begin
                    if (!empty && !round_exec_active) begin
                        if (head_eom) begin
                            msg_done <= 1'b1;
                            state    <= WAIT_DIG;
                        end else begin
                            msg_byte <= head_byte;
                            valid_in <= 1'b1;
                            state    <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (load_byte) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    valid_in <= 1'b0;
                    if (len_cnt != 16'hFFFF) begin
                        len_cnt <= len_cnt + 16'd1;
                    end
                    state <= WAIT_RND;
                end
                WAIT_DIG: begin
                    if (dig_rise) begin
                        out_digest <= {digest[0], digest[1], digest[2],
                                       digest[3], digest[4], digest[5],
                                       digest[6], digest[7]};
                        out_len    <= len_cnt;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
